// File: rtl/hamming_uart_encoder_if.sv
// Bundle between user push logic, the encoder, and async_transmitter.
// Defining HAMMING_ERR_INJECT_EN adds the inj_en/inj_pos push-side fields.
interface hamming_uart_encoder_if;
  // Push: a nibble transfers on a rising clk edge where nib_valid && nib_ready.
  // nib_valid may be held while nib_ready is low. Nothing is stored and no error
  // is flagged in that case. Transmit: tx_start is a one-cycle pulse, and tx_data
  // is stable from before the pulse until the next load. tx_busy is
  // async_transmitter's TxD_busy.
  logic [3:0] nib_in;
  logic       nib_valid;
  logic       nib_ready;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
`ifdef HAMMING_ERR_INJECT_EN
  logic       inj_en;
  logic [2:0] inj_pos;

  modport master (
    output nib_in, nib_valid, tx_busy, inj_en, inj_pos,
    input  nib_ready, tx_start, tx_data
  );
  modport slave (
    input  nib_in, nib_valid, tx_busy, inj_en, inj_pos,
    output nib_ready, tx_start, tx_data
  );
`else
  modport master (
    output nib_in, nib_valid, tx_busy,
    input  nib_ready, tx_start, tx_data
  );
  modport slave (
    input  nib_in, nib_valid, tx_busy,
    output nib_ready, tx_start, tx_data
  );
`endif
endinterface

// File: rtl/hamming_uart_encoder.sv
// Hamming(7,4) encoder with a codeword FIFO that feeds async_transmitter one byte per codeword.
// Defining HAMMING_ERR_INJECT_EN enables single-bit fault injection on push.
module hamming_uart_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int LW        = AW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  hamming_uart_encoder_if.slave  bus,
  output logic [LW-1:0]          fifo_level,
  output logic [CNT_W-1:0]       frame_count,
  output logic [2:0]             fsm_state
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] START   = 3'd2;
  localparam logic [2:0] WAIT_HI = 3'd3;
  localparam logic [2:0] WAIT_LO = 3'd4;

  logic [2:0]    state;
  logic [1:0]    wait_cnt;
  logic [7:0]    tx_data_q;
  logic [6:0]    cw_clean;
  logic [6:0]    cw;
  logic [6:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          push;
  logic          pop;

  // Bit positions match the ECC_7 error_loc index, so a syndrome names the bit directly.
  always_comb begin
    cw_clean[0] = bus.nib_in[0] ^ bus.nib_in[1] ^ bus.nib_in[3];
    cw_clean[1] = bus.nib_in[0] ^ bus.nib_in[2] ^ bus.nib_in[3];
    cw_clean[2] = bus.nib_in[0];
    cw_clean[3] = bus.nib_in[1] ^ bus.nib_in[2] ^ bus.nib_in[3];
    cw_clean[4] = bus.nib_in[1];
    cw_clean[5] = bus.nib_in[2];
    cw_clean[6] = bus.nib_in[3];
  end

`ifdef HAMMING_ERR_INJECT_EN
  logic [6:0] inj_mask;

  always_comb begin
    inj_mask = '0;
    if (bus.inj_en && (bus.inj_pos != 3'd7)) inj_mask[bus.inj_pos] = 1'b1;
  end

  assign cw = cw_clean ^ inj_mask;
`else
  assign cw = cw_clean;
`endif

  // Full comes from the registered level, so a pop in the same cycle cannot admit a push.
  assign full          = (fifo_level == LW'(FIFO_DEPTH));
  assign push          = bus.nib_valid && !full;
  assign pop           = (state == LOAD);
  assign bus.nib_ready = !full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // WAIT_HI gives the transmitter four cycles to raise busy before the same byte is restarted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      tx_data_q   <= 8'h00;
      frame_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((fifo_level != '0) && !bus.tx_busy) state <= LOAD;
        end
        LOAD: begin
          tx_data_q <= {1'b0, mem[rd_ptr]};
          state     <= START;
        end
        START: begin
          wait_cnt <= '0;
          state    <= WAIT_HI;
        end
        WAIT_HI: begin
          if (bus.tx_busy)              state    <= WAIT_LO;
          else if (wait_cnt == 2'd3)    state    <= START;
          else                          wait_cnt <= wait_cnt + 1'b1;
        end
        WAIT_LO: begin
          if (!bus.tx_busy) begin
            state       <= IDLE;
            frame_count <= frame_count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_start = (state == START);
  assign bus.tx_data  = tx_data_q;
  assign fsm_state    = state;

endmodule
